uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: data word width, matching the upstream FIFO's data width.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range is CLKS_PER_BIT >= 2.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-005 SHALL have port fifo_empty, input, 1: upstream FIFO empty flag.
REQ-006 SHALL have port fifo_data, input, DWIDTH: upstream FIFO registered read data, valid one cycle after the read strobe.
REQ-007 SHALL have port fifo_rd_en, output, 1: read strobe to the upstream FIFO.
REQ-008 SHALL have port tx, output, 1: serial line; idles high.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, START, DATA, STOP.
REQ-011 SHALL drive fifo_rd_en = (state==IDLE) && !fifo_empty, combinationally; it SHALL never be high in any other state.
REQ-012 SHALL transition IDLE->FETCH on the cycle fifo_rd_en is high, and stay in IDLE while fifo_empty=1.
REQ-013 SHALL spend exactly 1 cycle in FETCH, latching fifo_data into a DWIDTH shift register, then go to START.
REQ-014 SHALL hold tx=0 for exactly CLKS_PER_BIT cycles in START.
REQ-015 SHALL shift out DWIDTH bits in DATA, LSB first, each held CLKS_PER_BIT cycles.
REQ-016 SHALL hold tx=1 for CLKS_PER_BIT cycles in STOP, then go to IDLE.
REQ-017 SHALL drive tx from a register (glitch-free), =1 in IDLE and FETCH.
REQ-018 SHALL use a baud counter of width clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1, wraps to 0, and is cleared on each state entry.
REQ-019 SHALL use a bit index counter of width clog2(DWIDTH+1) that terminates DATA after bit DWIDTH-1.
REQ-020 SHALL ignore fifo_empty changes outside IDLE; a write into the FIFO mid-frame has no effect until the frame ends.
REQ-021 SHALL, for back-to-back words, insert exactly 2 idle-high cycles (IDLE + FETCH) between the end of STOP and the next START.
REQ-022 SHALL have a frame length from fifo_rd_en high to return to IDLE of 1 + (DWIDTH+2)*CLKS_PER_BIT cycles.
REQ-023 SHALL NOT issue a read when fifo_empty=1, so it never underflows the FIFO.

Reset
REQ-024 SHALL, on rst, immediately force: state=IDLE, tx=1, busy=0, fifo_rd_en=0, baud and bit counters=0, shift register=0.
REQ-025 SHALL abort any frame in progress when rst is asserted mid-frame, with no partial bits after release; the word fetched for that frame is lost.
REQ-026 SHALL resume normal operation on the first clk edge after rst deassertion.

Structure
REQ-027 SHALL define in shared package uart_pkg: the FSM state encoding and the default CLKS_PER_BIT constant.
REQ-028 SHALL keep the baud counter as one natural sub-module, uart_baud_cnt (clear input, terminal-count output); all other logic stays in uart_tx.

Verification
REQ-029 SHALL verify reset: assert rst with fifo_empty=0 -> tx=1, busy=0, fifo_rd_en=0 throughout reset.
REQ-030 SHALL verify a single word: CLKS_PER_BIT=4, FIFO holding 0xA5 -> one rd_en pulse; tx low 4, then 1,0,1,0,0,1,0,1 at 4 cycles each, high 4; busy high for 41 cycles.
REQ-031 SHALL verify back-to-back words: FIFO holding 0x00, 0xFF -> exactly 2 rd_en pulses and exactly 2 high cycles between frames.
REQ-032 SHALL verify starvation: fifo_empty=1 for 100 cycles -> no rd_en, tx=1, busy=0.
REQ-033 SHALL verify mid-frame writes: fifo_empty falls during DATA -> rd_en stays 0 until IDLE.
REQ-034 SHALL verify reset mid-DATA: rst asserted at bit 3 -> tx=1 in the same cycle, IDLE after release, and the next word is transmitted cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding and default bit timing.
package uart_pkg;

  // Default number of clk cycles per serial bit.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

  // FSM state encoding.
  localparam int unsigned StateW = 3;
  localparam logic [StateW-1:0] StIdle  = 3'd0;
  localparam logic [StateW-1:0] StFetch = 3'd1;
  localparam logic [StateW-1:0] StStart = 3'd2;
  localparam logic [StateW-1:0] StData  = 3'd3;
  localparam logic [StateW-1:0] StStop  = 3'd4;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last cycle of a bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  // Next count: clear on request or at terminal count, otherwise increment.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pulls words from an upstream FIFO and sends them 8N1-style, LSB first.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned IdxW = $clog2(DWIDTH + 1);

  logic [StateW-1:0] state_q, state_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic              baud_clr;
  logic              baud_tc;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(baud_clr),
    .tc_o (baud_tc)
  );

  // Reads only from IDLE; gated by rst so no strobe leaks out while held in reset.
  assign fifo_rd_en = (state_q == StIdle) && !fifo_empty && !rst;
  assign busy       = (state_q != StIdle);
  assign tx         = tx_q;

  // Counter restarts on every state entry and is held at zero while not timing bits.
  assign baud_clr = (state_d != state_q) || (state_q == StIdle) || (state_q == StFetch);

  // Next-state, shift register and bit index; tx is derived from the next state so the
  // registered line lines up exactly with the state it belongs to.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      StIdle: begin
        if (fifo_rd_en) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        shift_d   = fifo_data;
        bit_idx_d = '0;
        state_d   = StStart;
      end
      StStart: begin
        if (baud_tc) begin
          state_d = StData;
        end
      end
      StData: begin
        if (baud_tc) begin
          if (bit_idx_q == IdxW'(DWIDTH - 1)) begin
            bit_idx_d = '0;
            state_d   = StStop;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      StStop: begin
        if (baud_tc) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    tx_d = (state_d == StData) ? shift_d[0] : (state_d != StStart);
  end

  // State registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, DWIDTH=8 and a small registered FIFO model.
module tb_uart_tx;

  localparam int unsigned Cpb = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: registered read data, one cycle after the strobe.
  logic [7:0] mem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always #5 clk = ~clk;

  uart_tx #(
    .DWIDTH      (8),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy)
  );

  logic tx_log[$];
  logic busy_log[$];
  logic rd_log[$];
  logic exp_tx[$];
  logic exp_busy[$];
  logic exp_rd[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // Start and end on a falling edge; sample 1 time unit after it.
  task automatic sample_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      tx_log.push_back(tx);
      busy_log.push_back(busy);
      rd_log.push_back(fifo_rd_en);
      @(negedge clk);
    end
  endtask

  task automatic add_seg(input logic t, input logic b, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(t);
      exp_busy.push_back(b);
      exp_rd.push_back(r);
    end
  endtask

  // One frame starting at the IDLE cycle that issues the read; bits given in line order.
  task automatic add_frame(input logic [0:7] line_bits);
    add_seg(1'b1, 1'b0, 1'b1, 1);
    add_seg(1'b1, 1'b1, 1'b0, 1);
    add_seg(1'b0, 1'b1, 1'b0, Cpb);
    for (int k = 0; k < 8; k++) begin
      add_seg(line_bits[k], 1'b1, 1'b0, Cpb);
    end
    add_seg(1'b1, 1'b1, 1'b0, Cpb);
  endtask

  task automatic compare_logs(input string tag);
    for (int i = 0; i < tx_log.size(); i++) begin
      check_eq($sformatf("%s_tx[%0d]", tag, i), 32'(tx_log[i]), 32'(exp_tx[i]));
      check_eq($sformatf("%s_busy[%0d]", tag, i), 32'(busy_log[i]), 32'(exp_busy[i]));
      check_eq($sformatf("%s_rd[%0d]", tag, i), 32'(rd_log[i]), 32'(exp_rd[i]));
    end
  endtask

  task automatic clear_logs();
    tx_log.delete();
    busy_log.delete();
    rd_log.delete();
    exp_tx.delete();
    exp_busy.delete();
    exp_rd.delete();
  endtask

  function automatic int count_rd(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < rd_log.size(); i++) begin
      if (rd_log[i] === 1'b1) n++;
    end
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset held with a non-empty FIFO.
    push(8'hA5);
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("rst_tx[%0d]", i), 32'(tx), 32'd1);
      check_eq($sformatf("rst_busy[%0d]", i), 32'(busy), 32'd0);
      check_eq($sformatf("rst_rd[%0d]", i), 32'(fifo_rd_en), 32'd0);
    end

    // Single word 0xA5: line order 1,0,1,0,0,1,0,1.
    @(negedge clk);
    rst = 1'b0;
    add_frame(8'b10100101);
    add_seg(1'b1, 1'b0, 1'b0, 18);
    sample_cycles(60);
    compare_logs("a5");
    check_eq("a5_rd_pulses", 32'(count_rd(0, 59)), 32'd1);
    n = 0;
    foreach (busy_log[i]) if (busy_log[i] === 1'b1) n++;
    check_eq("a5_busy_cycles", 32'(n), 32'd41);
    clear_logs();

    // Back-to-back 0x00 then 0xFF.
    push(8'h00);
    push(8'hFF);
    add_frame(8'b00000000);
    add_frame(8'b11111111);
    add_seg(1'b1, 1'b0, 1'b0, 16);
    sample_cycles(100);
    compare_logs("b2b");
    check_eq("b2b_rd_pulses", 32'(count_rd(0, 99)), 32'd2);
    // 4 stop cycles plus IDLE and FETCH before the second start bit.
    n = 0;
    for (int i = 38; i < 100 && tx_log[i] === 1'b1; i++) n++;
    check_eq("b2b_high_gap", 32'(n), 32'd6);
    clear_logs();

    // Starvation.
    add_seg(1'b1, 1'b0, 1'b0, 100);
    sample_cycles(100);
    compare_logs("starve");
    check_eq("starve_rd_pulses", 32'(count_rd(0, 99)), 32'd0);
    clear_logs();

    // Word written while the previous frame is in DATA.
    push(8'h3C);
    add_frame(8'b00111100);
    add_frame(8'b10000001);
    add_seg(1'b1, 1'b0, 1'b0, 16);
    sample_cycles(20);
    push(8'h81);
    sample_cycles(80);
    compare_logs("mid");
    check_eq("mid_rd_in_frame", 32'(count_rd(1, 41)), 32'd0);
    check_eq("mid_rd_after", 32'(rd_log[42]), 32'd1);
    clear_logs();

    // Reset during bit 3 of 0x52 (line order 0,1,0,0,1,0,1,0).
    push(8'h52);
    add_frame(8'b01001010);
    sample_cycles(19);
    compare_logs("abort_pre");
    clear_logs();
    rst = 1'b1;
    #1;
    check_eq("abort_tx", 32'(tx), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rd", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    push(8'hC3);
    #1;
    check_eq("abort_hold_tx", 32'(tx), 32'd1);
    check_eq("abort_hold_rd", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    add_frame(8'b11000011);
    add_seg(1'b1, 1'b0, 1'b0, 8);
    sample_cycles(50);
    compare_logs("post");
    check_eq("post_rd_pulses", 32'(count_rd(0, 49)), 32'd1);
    clear_logs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
